// File: rtl/period_meter.sv
// Measures sigIn period and high time in inClk cycles between consecutive
// synchronized rising edges; saturates to a sticky overflow if no edge arrives.
module period_meter #(
    parameter int WIDTH = 16
) (
    input  logic             inClk,
    input  logic             reset,
    input  logic             sigIn,
    input  logic             measureEn,
    output logic [WIDTH-1:0] periodOut,
    output logic [WIDTH-1:0] highOut,
    output logic             validOut,
    output logic             overflow
);
    typedef enum logic {IDLE = 1'b0, MEASURE = 1'b1} state_e;

    localparam logic [WIDTH-1:0] CNT_MAX = '1;
    localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);

    state_e           state_q, state_d;
    logic             s1_q, s2_q, prev_q;
    logic [WIDTH-1:0] period_cnt_q, period_cnt_d;
    logic [WIDTH-1:0] high_cnt_q, high_cnt_d;
    logic [WIDTH-1:0] period_out_q, period_out_d;
    logic [WIDTH-1:0] high_out_q, high_out_d;
    logic             valid_q, valid_d;
    logic             ovf_q, ovf_d;
    logic             rise;

    assign rise = s2_q & ~prev_q;

    always_ff @(posedge inClk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            s1_q         <= 1'b0;
            s2_q         <= 1'b0;
            prev_q       <= 1'b0;
            period_cnt_q <= '0;
            high_cnt_q   <= '0;
            period_out_q <= '0;
            high_out_q   <= '0;
            valid_q      <= 1'b0;
            ovf_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            s1_q         <= sigIn;
            s2_q         <= s1_q;
            prev_q       <= s2_q;
            period_cnt_q <= period_cnt_d;
            high_cnt_q   <= high_cnt_d;
            period_out_q <= period_out_d;
            high_out_q   <= high_out_d;
            valid_q      <= valid_d;
            ovf_q        <= ovf_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        period_cnt_d = period_cnt_q;
        high_cnt_d   = high_cnt_q;
        period_out_d = period_out_q;
        high_out_d   = high_out_q;
        valid_d      = 1'b0;
        ovf_d        = ovf_q;
        if (!measureEn) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (rise) begin
                        state_d      = MEASURE;
                        period_cnt_d = CNT_ONE;
                        high_cnt_d   = CNT_ONE;
                    end
                end
                MEASURE: begin
                    // A rise in the saturation cycle still captures the full count.
                    if (rise) begin
                        period_out_d = period_cnt_q;
                        high_out_d   = high_cnt_q;
                        valid_d      = 1'b1;
                        ovf_d        = 1'b0;
                        period_cnt_d = CNT_ONE;
                        high_cnt_d   = CNT_ONE;
                    end else if (period_cnt_q == CNT_MAX) begin
                        ovf_d   = 1'b1;
                        state_d = IDLE;
                    end else begin
                        period_cnt_d = period_cnt_q + CNT_ONE;
                        high_cnt_d   = high_cnt_q + WIDTH'(s2_q);
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign periodOut = period_out_q;
    assign highOut   = high_out_q;
    assign validOut  = valid_q;
    assign overflow  = ovf_q;
endmodule

// File: tb/tb_period_meter.sv
// Bench for period_meter: WIDTH=16 and WIDTH=4 instances share stimulus and are
// checked every cycle against a timestamp-based model of rise-to-rise intervals.
module tb_period_meter;
    logic        inClk = 1'b0;
    logic        reset = 1'b0;
    logic        sigIn = 1'b0;
    logic        measureEn = 1'b0;
    logic [15:0] p16, h16;
    logic [3:0]  p4, h4;
    logic        v16, o16, v4, o4;

    int n_cmp = 0;
    int n_fail = 0;

    period_meter u_dut16 (
        .inClk(inClk), .reset(reset), .sigIn(sigIn), .measureEn(measureEn),
        .periodOut(p16), .highOut(h16), .validOut(v16), .overflow(o16)
    );

    period_meter #(.WIDTH(4)) u_dut4 (
        .inClk(inClk), .reset(reset), .sigIn(sigIn), .measureEn(measureEn),
        .periodOut(p4), .highOut(h4), .validOut(v4), .overflow(o4)
    );

    always #5 inClk = ~inClk;

    // Model: index 0 = WIDTH 16, index 1 = WIDTH 4.
    int maxc[2] = '{65535, 15};
    int armed[2];
    int last_rise[2];
    int e_per[2], e_high[2], e_val[2], e_ovf[2];
    bit s2h[0:16383];
    bit sh[3];   // sigIn as sampled 1, 2 and 3 edges ago
    int k = 0;

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            armed[d] = 0; last_rise[d] = 0;
            e_per[d] = 0; e_high[d] = 0; e_val[d] = 0; e_ovf[d] = 0;
        end
        for (int i = 0; i < 3; i++) sh[i] = 1'b0;
    endtask

    task automatic model_edge(input bit s, input bit en);
        bit s2, rise;
        int hs;
        s2   = sh[1];
        rise = sh[1] & ~sh[2];
        s2h[k] = s2;
        for (int d = 0; d < 2; d++) begin
            e_val[d] = 0;
            if (!en) begin
                armed[d] = 0;
            end else if (rise) begin
                if (armed[d] != 0) begin
                    hs = 0;
                    for (int j = last_rise[d]; j < k; j++) hs += int'(s2h[j]);
                    e_per[d]  = k - last_rise[d];
                    e_high[d] = hs;
                    e_val[d]  = 1;
                    e_ovf[d]  = 0;
                end
                armed[d]     = 1;
                last_rise[d] = k;
            end else if (armed[d] != 0 && (k - last_rise[d]) >= maxc[d]) begin
                e_ovf[d] = 1;
                armed[d] = 0;
            end
        end
        sh[2] = sh[1];
        sh[1] = sh[0];
        sh[0] = s;
        k++;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s cyc=%0d got=%0d exp=%0d", tag, k, got, exp);
        end
    endtask

    task automatic check_all();
        chk("per16",  32'(p16), e_per[0]);
        chk("high16", 32'(h16), e_high[0]);
        chk("val16",  32'(v16), e_val[0]);
        chk("ovf16",  32'(o16), e_ovf[0]);
        chk("per4",   32'(p4),  e_per[1]);
        chk("high4",  32'(h4),  e_high[1]);
        chk("val4",   32'(v4),  e_val[1]);
        chk("ovf4",   32'(o4),  e_ovf[1]);
    endtask

    // Called 1 ns after a rising edge; drives inputs then checks after the next edge.
    task automatic step(input bit s, input bit en);
        sigIn     = s;
        measureEn = en;
        @(posedge inClk);
        model_edge(s, en);
        #1;
        check_all();
    endtask

    task automatic wave(input int per, input int hi, input int reps, input bit en);
        for (int r = 0; r < reps; r++) begin
            for (int c = 0; c < per; c++) step(c < hi, en);
        end
    endtask

    // Short asynchronous reset pulse placed between clock edges.
    task automatic pulse_reset();
        #1 reset = 1'b0;
        model_reset();
        #1 check_all();
        #4 reset = 1'b1;
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge inClk);
        #1 check_all();
        reset = 1'b1;

        wave(8, 4, 6, 1'b1);
        wave(10, 3, 5, 1'b1);
        for (int i = 0; i < 20; i++) step(1'b0, 1'b1);
        wave(6, 3, 3, 1'b1);
        wave(15, 5, 3, 1'b1);
        wave(16, 5, 3, 1'b1);
        wave(2, 1, 1, 1'b1);
        wave(6, 2, 3, 1'b1);

        // measureEn dropped mid-period, then restored
        wave(9, 4, 3, 1'b1);
        step(1'b1, 1'b1); step(1'b1, 1'b1); step(1'b0, 1'b1);
        wave(9, 4, 2, 1'b0);
        wave(9, 4, 4, 1'b1);

        // reset mid-period
        wave(12, 6, 3, 1'b1);
        step(1'b1, 1'b1); step(1'b1, 1'b1); step(1'b0, 1'b1);
        pulse_reset();
        wave(12, 6, 4, 1'b1);

        // sigIn already high across reset release
        step(1'b1, 1'b1);
        pulse_reset();
        step(1'b1, 1'b1); step(1'b1, 1'b1); step(1'b0, 1'b1); step(1'b0, 1'b1);
        wave(7, 3, 4, 1'b1);

        for (int seg = 0; seg < 40; seg++) begin
            int per, hi, reps;
            bit en;
            per  = $urandom_range(20, 4);
            hi   = $urandom_range(per - 2, 2);
            reps = $urandom_range(4, 1);
            en   = ($urandom_range(7, 0) != 0);
            wave(per, hi, reps, en);
            if ($urandom_range(15, 0) == 0) pulse_reset();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
